// File: rtl/uart_tx.sv
// Asynchronous-serial transmitter: start bit, WIDTH data bits LSB-first,
// optional even parity, stop bit, each held for CLKS_PER_BIT clocks.
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic             par, par_n;
    logic             tx_n, busy_n, done_n;
    logic             bit_end;

    assign ready   = (state == IDLE) && !reset;
    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            par   <= par_n;
            tx    <= tx_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Outputs are registered, so they are derived from the next state/shift
    // values: the start bit then appears on the cycle right after accept.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        par_n   = par;

        case (state)
            IDLE: begin
                if (valid && ready) begin
                    state_n = START;
                    cnt_n   = '0;
                    idx_n   = '0;
                    shift_n = d;
                    par_n   = ^d;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shift >> 1;
                    if (idx == IDX_LAST) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        done_n = (state == STOP) && (state_n == IDLE);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized frame checks for uart_tx, with and without parity,
// against a bit-level frame model evaluated every clock.
module tb_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] d0, d1;
    logic         valid0, valid1;
    logic         ready0, tx0, busy0, done0;
    logic         ready1, tx1, busy1, done1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
        .clk(clk), .reset(reset), .d(d0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
    );

    uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
        .clk(clk), .reset(reset), .d(d1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit j: 0 start, data LSB-first, parity, 1 stop.
    function automatic logic model_bit(input logic [W-1:0] w, input bit pe, input int j);
        if (j == 0) return 1'b0;
        if (j <= W) return w[j-1];
        if (pe && j == W + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic check_outs(input bit pe, input string tag,
                              input logic etx, input logic ebusy,
                              input logic edone, input logic eready);
        chk({tag, ".tx"},    pe ? tx1 : tx0,       etx);
        chk({tag, ".busy"},  pe ? busy1 : busy0,   ebusy);
        chk({tag, ".done"},  pe ? done1 : done0,   edone);
        chk({tag, ".ready"}, pe ? ready1 : ready0, eready);
    endtask

    // Called at a negedge with the DUT idle; returns at the done-cycle negedge.
    // hold keeps valid high; scramble changes d every cycle of the frame.
    task automatic frame(input logic [W-1:0] w, input bit pe, input bit hold,
                         input bit scramble, input string tag);
        int len;
        len = CPB * (W + 2 + (pe ? 1 : 0));
        if (pe) begin d1 = w; valid1 = 1'b1; end
        else    begin d0 = w; valid0 = 1'b1; end
        chk({tag, ".ready_at_accept"}, pe ? ready1 : ready0, 1'b1);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (!hold) begin
                if (pe) valid1 = 1'b0; else valid0 = 1'b0;
            end
            if (scramble) begin
                if (pe) d1 = W'($urandom); else d0 = W'($urandom);
                if (k == 8)  begin if (pe) d1 = 8'h55; else d0 = 8'h55; end
                if (k == 20) begin if (pe) d1 = 8'hFF; else d0 = 8'hFF; end
            end
            check_outs(pe, tag, model_bit(w, pe, k / CPB), 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        check_outs(pe, {tag, ".end"}, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic idle(input bit pe, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_outs(pe, tag, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset  = 1'b1;
        d0     = '0;
        d1     = '0;
        valid0 = 1'b0;
        valid1 = 1'b0;

        // Reset held for 20 time units
        #7;
        check_outs(0, "rst_a", 1'b1, 1'b0, 1'b0, 1'b0);
        check_outs(1, "rst_a_p", 1'b1, 1'b0, 1'b0, 1'b0);
        #10;
        check_outs(0, "rst_b", 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        idle(0, 2, "post_rst");
        idle(1, 1, "post_rst_p");

        // Single frame, valid pulsed
        frame(8'hAA, 0, 0, 0, "aa");
        idle(0, 3, "aa_idle");

        // Input changes mid-frame are ignored
        frame(8'hAA, 0, 0, 1, "aa_scr");
        idle(0, 6, "aa_scr_idle");

        // Back-to-back with valid held; new word presented in the done cycle
        frame(8'h55, 0, 1, 0, "b2b_55");
        frame(8'hCC, 0, 0, 0, "b2b_cc");
        idle(0, 3, "b2b_idle");

        // Reset during data bit 3 of 8'hFF
        d0 = 8'hFF;
        valid0 = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            valid0 = 1'b0;
        end
        chk("mid.busy_before", busy0, 1'b1);
        chk("mid.tx_before", tx0, 1'b1);
        reset = 1'b1;
        #1;
        check_outs(0, "mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs(0, "mid_rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(0, 2, "mid_after");
        frame(8'h33, 0, 0, 0, "f33");
        idle(0, 1, "f33_idle");

        // Parity instance
        frame(8'h07, 1, 0, 0, "par07");
        idle(1, 1, "par07_idle");
        frame(8'h03, 1, 0, 0, "par03");
        idle(1, 1, "par03_idle");

        // Randomized words on both instances, random back-to-back
        for (int i = 0; i < 6; i++) begin
            frame(W'($urandom), 0, 0, 0, "rnd");
            if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(1, 3), "rnd_idle");
            frame(W'($urandom), 1, 0, 0, "rnd_p");
            idle(1, 1, "rnd_p_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Parameterised serial transmitter that takes a WIDTH-bit parallel word over a valid/ready handshake and shifts it out on a single line as an asynchronous-serial frame: start bit, data LSB-first, optional even parity, stop bit.
It is the transmit end of the team's serial link. Its registered parallel source feeds d/valid, and the matching receiver samples tx.
Each bit is held for CLKS_PER_BIT clock cycles.

Parameters:
WIDTH, 8, number of data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles per serial bit (>=1)
PARITY_EN, 0, 1 = append even-parity bit after the data bits; 0 = no parity bit

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
d  input  WIDTH  parallel data word to send
valid  input  1  d holds a word to send
ready  output  1  transmitter can accept a word this cycle
tx  output  1  serial line; idles high
busy  output  1  a frame is in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values, applied immediately while reset=1:
  - state=IDLE, tx=1, busy=0, done=0, shift register=0, counters=0.
  - ready=0 while reset=1; ready=1 from the first cycle after release.
- All outputs are registered except ready, which is ready = (state==IDLE) && !reset.
- Handshake:
  - A transfer occurs on the rising edge where valid && ready.
  - d is latched into the shift register on that edge. d and valid are ignored for the rest of the frame.
  - valid may stay high; it is not consumed outside IDLE.
- Counters:
  - Bit-period counter width is $clog2(CLKS_PER_BIT), with a minimum of 1. It counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit-index counter width is $clog2(WIDTH)+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. On accept, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, beginning the cycle after accept. Then go to DATA.
  - DATA: tx=shift[0]. The register shifts right every CLKS_PER_BIT cycles. After WIDTH bits, go to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: tx = XOR of the latched word (even parity over data plus parity bit). Lasts CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- busy=1 in START, DATA, PARITY and STOP. ready=0 throughout the frame.
- done=1 for exactly the first IDLE cycle after STOP.
- Frame length from the first start-bit cycle to the last stop-bit cycle is CLKS_PER_BIT*(WIDTH+2+PARITY_EN) cycles.
- Back-to-back frames:
  - If valid is high in the done cycle, the next word is accepted on that same edge.
  - Its start bit begins the following cycle. The minimum gap between the stop bit and the next start bit is one idle cycle with tx=1.
- Reset mid-frame:
  - tx returns to 1 immediately, the state goes to IDLE, and no done pulse is issued.
  - The partial frame is discarded and is not resumed.
- CLKS_PER_BIT=1 is legal: one cycle per bit with no counter stall.

Test Plan:
All scenarios use WIDTH=8 and CLKS_PER_BIT=4 unless stated.
1. Assert reset for 20 time units, then release → tx=1, busy=0, done=0 during and after reset; ready=0 during reset and 1 after.
2. Apply d=8'hAA with valid pulsed one cycle (PARITY_EN=0) → tx bit sequence 0,0,1,0,1,0,1,0,1,1, each bit 4 cycles (40 cycles); busy high for 40 cycles; single done pulse; ready low throughout.
3. Accept 8'hAA, then change d to 8'h55 and 8'hFF mid-frame with valid low → transmitted frame is still 8'hAA; no second frame.
4. Hold valid=1 while d=8'h55, then set d=8'hCC during the done cycle → frames 8'h55 then 8'hCC; exactly one tx=1 idle cycle between the stop bit and the next start bit; two done pulses.
5. Send 8'hFF and assert reset during data bit 3 → tx=1 immediately, busy=0, no done. After release, send 8'h33 → clean frame 0,1,1,0,0,1,1,0,0,1.
6. Set PARITY_EN=1 and send 8'h07 → parity bit 1, frame 44 cycles. Send 8'h03 → parity bit 0.
